// File: rtl/m_wbarb_defs.sv
// -----------------------------------------------------------------------------
// m_wbarb_defs
//   Shared definitions for the two-master Wishbone arbiter (m_wbarb2):
//   ownership state encodings and the default stall-timeout counter width.
//   No ports.
// -----------------------------------------------------------------------------
package m_wbarb_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    localparam int DEF_TOWIDTH = 6;

endpackage

// File: rtl/m_wbarb_timeout.sv
// -----------------------------------------------------------------------------
// m_wbarb_timeout
//   Stall counter for the arbiter's slave port. Counts consecutive cycles
//   with the owner's strobe high and no slave ACK; raises a one-cycle
//   expire pulse on the (2^TOWIDTH-1)-th such cycle and restarts.
//   Only instantiated when WBARB_TIMEOUT_EN is defined.
//
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     stb_i    in   owner strobe before any timeout forcing
//     ack_i    in   slave acknowledge
//     expire_o out  stall limit reached this cycle (never while ack_i=1)
// -----------------------------------------------------------------------------
module m_wbarb_timeout
    import m_wbarb_defs::*;
#(
    parameter int TOWIDTH = DEF_TOWIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb_i,
    input  logic ack_i,
    output logic expire_o
);

    // The counter holds (stalled cycles so far - 1) at the start of a stalled
    // cycle, so the cycle that would take it to all-ones is the expiring one.
    localparam logic [TOWIDTH-1:0] CNT_LAST = TOWIDTH'((1 << TOWIDTH) - 2);

    logic [TOWIDTH-1:0] cnt_q;
    logic [TOWIDTH-1:0] cnt_d;

    always_comb begin
        // A late ACK on the expiring cycle takes precedence over the timeout.
        expire_o = stb_i & ~ack_i & (cnt_q == CNT_LAST);
        cnt_d    = cnt_q;
        if (!stb_i || ack_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TOWIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/m_wbarb2.sv
// -----------------------------------------------------------------------------
// m_wbarb2
//   Two-master Wishbone B4 classic arbiter. Master 0 (core) and master 1
//   (loader/debug DMA) share one slave port. The owner keeps the bus for its
//   whole CYC; contention from IDLE is resolved round-robin against `last`.
//   One IDLE cycle always separates two owners.
//
//   Optional feature macro: WBARB_TIMEOUT_EN -- when defined, a stalled
//   strobe is terminated with ERR to the owner after 2^TOWIDTH-1 cycles.
//   When undefined, ERR outputs are tied 0 and TOWIDTH is ignored.
//
//   Ports:
//     CLK_I, RST_NI                    clock, async active-low reset
//     mN_CYC_I/STB_I/WE_I              master N control
//     mN_ADR_I/DAT_I/SEL_I             master N payload
//     mN_ACK_O/ERR_O                   terminations, routed to owner only
//     mN_DAT_O                         slave read data, broadcast
//     CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O  slave-side signals from owner
//     ACK_I, DAT_I                     slave acknowledge and read data
// -----------------------------------------------------------------------------
module m_wbarb2
    import m_wbarb_defs::*;
#(
    parameter int TOWIDTH  = DEF_TOWIDTH,
    parameter int ADRWIDTH = 32
) (
    input  logic                CLK_I,
    input  logic                RST_NI,
    input  logic                m0_CYC_I,
    input  logic                m0_STB_I,
    input  logic                m0_WE_I,
    input  logic [ADRWIDTH-1:0] m0_ADR_I,
    input  logic [31:0]         m0_DAT_I,
    input  logic [3:0]          m0_SEL_I,
    output logic                m0_ACK_O,
    output logic                m0_ERR_O,
    output logic [31:0]         m0_DAT_O,
    input  logic                m1_CYC_I,
    input  logic                m1_STB_I,
    input  logic                m1_WE_I,
    input  logic [ADRWIDTH-1:0] m1_ADR_I,
    input  logic [31:0]         m1_DAT_I,
    input  logic [3:0]          m1_SEL_I,
    output logic                m1_ACK_O,
    output logic                m1_ERR_O,
    output logic [31:0]         m1_DAT_O,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    output logic [ADRWIDTH-1:0] ADR_O,
    output logic [31:0]         DAT_O,
    output logic [3:0]          SEL_O,
    input  logic                ACK_I,
    input  logic [31:0]         DAT_I
);

    state_e state_q;
    state_e state_d;
    logic   last_q;
    logic   last_d;
    logic   own_stb;
    logic   expire;

    // State register
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: grants only happen from IDLE, so an owner holding
    // CYC can never be pre-empted (locked read-modify-write is safe).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_CYC_I && m1_CYC_I) begin
                    if (last_q) begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end
                end else if (m0_CYC_I) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1_CYC_I) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: if (!m0_CYC_I) state_d = IDLE;
            OWN1: if (!m1_CYC_I) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner strobe before timeout forcing; kept apart from the output mux so
    // the timeout unit sees it without a combinational loop.
    assign own_stb = (state_q == OWN0) ? m0_STB_I :
                     (state_q == OWN1) ? m1_STB_I : 1'b0;

`ifdef WBARB_TIMEOUT_EN
    m_wbarb_timeout #(
        .TOWIDTH (TOWIDTH)
    ) u_timeout (
        .clk      (CLK_I),
        .rst_n    (RST_NI),
        .stb_i    (own_stb),
        .ack_i    (ACK_I),
        .expire_o (expire)
    );
`else
    localparam int unused_towidth = TOWIDTH;
    assign expire = 1'b0;
`endif

    // Output logic: slave side follows the owner combinationally; IDLE and
    // reset leave every slave-side signal at 0.
    always_comb begin
        CYC_O    = 1'b0;
        WE_O     = 1'b0;
        ADR_O    = '0;
        DAT_O    = '0;
        SEL_O    = '0;
        STB_O    = own_stb & ~expire;
        m0_ACK_O = 1'b0;
        m1_ACK_O = 1'b0;
        m0_ERR_O = 1'b0;
        m1_ERR_O = 1'b0;
        case (state_q)
            OWN0: begin
                CYC_O    = m0_CYC_I;
                WE_O     = m0_WE_I;
                ADR_O    = m0_ADR_I;
                DAT_O    = m0_DAT_I;
                SEL_O    = m0_SEL_I;
                m0_ACK_O = ACK_I & STB_O;
                m0_ERR_O = expire;
            end
            OWN1: begin
                CYC_O    = m1_CYC_I;
                WE_O     = m1_WE_I;
                ADR_O    = m1_ADR_I;
                DAT_O    = m1_DAT_I;
                SEL_O    = m1_SEL_I;
                m1_ACK_O = ACK_I & STB_O;
                m1_ERR_O = expire;
            end
            default: ;
        endcase
    end

    // Read data is a plain broadcast; only ACK qualifies it for a master.
    assign m0_DAT_O = DAT_I;
    assign m1_DAT_O = DAT_I;

endmodule

// File: doc/m_wbarb2.md
# m_wbarb2

Two-master Wishbone B4 classic arbiter placed between bus masters and the shared slave fabric (the wishbone register and its address decode). Master 0 is the midgetv core; master 1 is a secondary requester (loader/debug DMA). The block grants the slave port to one master for the full duration of its CYC, alternates priority round-robin on contention, and optionally terminates stalled cycles with ERR after a programmable timeout.

## Interface
- TOWIDTH, 6: width of the stall counter; timeout fires after 2^TOWIDTH-1 stalled cycles.
- ADRWIDTH, 32: address width on all ports.
- CLK_I  input  1  clock; all state changes on rising edge.
- RST_NI  input  1  reset, asynchronous, active-low.
- m0_CYC_I / m1_CYC_I  input  1  master cycle request.
- m0_STB_I / m1_STB_I  input  1  master strobe.
- m0_WE_I / m1_WE_I  input  1  master write enable.
- m0_ADR_I / m1_ADR_I  input  ADRWIDTH  master address.
- m0_DAT_I / m1_DAT_I  input  32  master write data.
- m0_SEL_I / m1_SEL_I  input  4  master byte selects.
- m0_ACK_O / m1_ACK_O  output  1  slave ACK routed to owner only.
- m0_ERR_O / m1_ERR_O  output  1  timeout termination to owner only.
- m0_DAT_O / m1_DAT_O  output  32  read data (slave DAT_I broadcast to both).
- CYC_O, STB_O, WE_O  output  1  slave-side control from owner.
- ADR_O  output  ADRWIDTH; DAT_O output 32; SEL_O output 4  slave-side payload from owner.
- ACK_I  input  1  slave acknowledge.
- DAT_I  input  32  slave read data.

## Operation
- States: IDLE, OWN0, OWN1. Registered; encoding 2 bits.
- IDLE: no master owns bus; CYC_O/STB_O/WE_O=0, ADR_O/DAT_O/SEL_O=0.
- IDLE, only mN_CYC_I=1 -> OWNN next cycle.
- IDLE, both CYC=1 -> grant master other than `last`; `last` register updated to granted master on each grant. Reset value of `last` is 1, so master 0 wins first contention.
- OWNN: slave outputs combinationally driven from master N; mN_ACK_O=ACK_I & STB_O; other master's ACK/ERR=0.
- OWNN, mN_CYC_I=0 -> IDLE next cycle (one dead cycle between owners; no direct handover).
- Non-owner requests are held off (no ACK) until grant; they must keep CYC/STB asserted.
- Ownership never changes while owner CYC=1, regardless of other requests (supports locked read-modify-write).
- Timeout (macro on): counter clears on any cycle with STB_O=0 or ACK_I=1, increments when STB_O=1 & ACK_I=0. On reaching all-ones: mN_ERR_O=1 for exactly one cycle, STB_O forced 0 that cycle, counter clears. ACK_I arriving on the timeout cycle wins: ACK delivered, no ERR.
- Reset mid-cycle: state->IDLE, counter->0, `last`->1 immediately (async); all outputs drop to 0 asynchronously.

## Timing
- Grant latency: CYC asserted in cycle k from IDLE -> CYC_O/STB_O from owner in cycle k+1.
- ACK path purely combinational (ACK_I to mN_ACK_O, zero latency); zero-wait-state slaves keep single-cycle throughput within a granted burst.
- Release: owner CYC low in cycle j -> IDLE in j+1 -> next grant visible j+2.
- Reset values: all outputs 0.

## Configuration
- WBARB_TIMEOUT_EN defined: stall counter present, ERR outputs functional as above.
- Not defined: no counter flops, m0_ERR_O=m1_ERR_O=0 constant, STB_O never forced; a stalled slave hangs the owner indefinitely. TOWIDTH ignored.

## Structure
- Shared include/package m_wbarb_defs: state encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and default TOWIDTH.
- One sub-module: m_wbarb_timeout (counter, clear/increment, one-cycle expire pulse), instantiated only under WBARB_TIMEOUT_EN.
- Top holds state register, `last`, and output muxes.

## Test plan
- Reset: assert RST_NI=0 mid-burst with OWN1 -> all outputs 0 same cycle; after release, m0 and m1 request together -> m0 owns at k+1.
- Contention: both request continuously, each does 1-transfer cycle -> ownership alternates 0,1,0,1 with one IDLE cycle between.
- Lock: m0 holds CYC for 4 writes (ADR 0x40000004, DAT 0xDEADBEEF), m1 requests throughout -> m1 granted only 2 cycles after m0 drops CYC.
- ACK routing: OWN0, slave ACK_I with DAT_I=0x12345678 -> m0_ACK_O=1, m0_DAT_O=0x12345678, m1_ACK_O=0.
- Timeout (TOWIDTH=4, macro on): slave never ACKs -> m0_ERR_O pulses on 15th stalled cycle, STB_O=0 that cycle; ACK_I on that cycle -> ACK, no ERR.
- Macro off: same stall for 100 cycles -> ERR outputs stay 0, STB_O stays 1.
